// File: rtl/sap_register_bank_pkg.sv
// -----------------------------------------------------------------------------
// sap_pkg
// Shared definitions for the SAP register bank: default sizes, the operation
// encoding driven on the op port, the control FSM states, and a select
// range helper used for banks whose size is not a power of two.
// -----------------------------------------------------------------------------
package sap_pkg;

  localparam int unsigned SAP_WIDTH    = 8;
  localparam int unsigned SAP_NUM_REGS = 4;

  typedef enum logic [1:0] {
    OP_INC = 2'b00,
    OP_DEC = 2'b01,
    OP_SHL = 2'b10,
    OP_SHR = 2'b11
  } sap_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } sap_state_e;

  // True when a select value addresses an implemented register.
  function automatic logic sel_in_range(input int unsigned sel,
                                        input int unsigned num_regs);
    return sel < num_regs;
  endfunction

endpackage

// File: rtl/sap_register_bank_shift_step.sv
// -----------------------------------------------------------------------------
// sap_shift_step
// Combinational single-bit shift of a WIDTH-bit word.
//   data_i    : word to shift
//   left_i    : 1 = shift toward MSB, 0 = shift toward LSB
//   data_o    : shifted word
//   out_bit_o : bit that left the word (MSB for left, LSB for right)
// Build option SAP_REGBANK_ROTATE_EN: when defined the outgoing bit re-enters
// at the opposite end (rotate); otherwise the vacated bit is zero-filled.
// -----------------------------------------------------------------------------
module sap_shift_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic             left_i,
  output logic [WIDTH-1:0] data_o,
  output logic             out_bit_o
);

  logic fill_left;
  logic fill_right;

`ifdef SAP_REGBANK_ROTATE_EN
  assign fill_left  = data_i[WIDTH-1];
  assign fill_right = data_i[0];
`else
  assign fill_left  = 1'b0;
  assign fill_right = 1'b0;
`endif

  always_comb begin
    if (left_i) begin
      data_o    = {data_i[WIDTH-2:0], fill_left};
      out_bit_o = data_i[WIDTH-1];
    end else begin
      data_o    = {fill_right, data_i[WIDTH-1:1]};
      out_bit_o = data_i[0];
    end
  end

endmodule

// File: rtl/sap_register_bank.sv
// -----------------------------------------------------------------------------
// sap_register_bank
// Bank of NUM_REGS general-purpose WIDTH-bit registers on the SAP data bus.
// Supports bus load, gated bus read, single-cycle INC/DEC and a multi-cycle
// shift-by-N with busy/done handshake.
// Ports:
//   clk, reset        : rising-edge clock, asynchronous active-high reset
//   load_n/wr_sel/data_in : active-low write of data_in into reg[wr_sel]
//   op_n/op/op_sel/shamt  : active-low start of op on reg[op_sel]
//   enable_n/rd_sel/data_out : data_out = reg[rd_sel] when enable_n=0, else 0
//   busy  : shift in progress       done  : one-cycle completion pulse
//   zero  : target == 0 after last completed op
//   carry : INC/DEC wrap or last bit shifted out
// Build option SAP_REGBANK_ROTATE_EN (in sap_shift_step) turns shifts into
// rotates.
// -----------------------------------------------------------------------------
module sap_register_bank
  import sap_pkg::*;
#(
  parameter  int WIDTH    = SAP_WIDTH,
  parameter  int NUM_REGS = SAP_NUM_REGS,
  localparam int SELW     = $clog2(NUM_REGS),
  localparam int SHW      = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_n,
  input  logic [SELW-1:0]  wr_sel,
  input  logic [WIDTH-1:0] data_in,
  input  logic             op_n,
  input  logic [1:0]       op,
  input  logic [SELW-1:0]  op_sel,
  input  logic [SHW-1:0]   shamt,
  input  logic             enable_n,
  input  logic [SELW-1:0]  rd_sel,
  output logic [WIDTH-1:0] data_out,
  output logic             busy,
  output logic             done,
  output logic             zero,
  output logic             carry
);

  logic [WIDTH-1:0] regs_q [NUM_REGS];
  logic [WIDTH-1:0] regs_d [NUM_REGS];
  sap_state_e       state_q, state_d;
  sap_op_e          shop_q, shop_d;   // direction of the shift in progress
  logic [SELW-1:0]  tgt_q, tgt_d;     // register owned by the current op
  logic [SHW-1:0]   cnt_q, cnt_d;     // shifts still to perform
  logic             carry_q, carry_d;
  logic             zero_q, zero_d;

  logic             load_ok, op_ok;
  logic [WIDTH-1:0] op_val, tgt_val, rd_val;
  logic [WIDTH-1:0] step_val;
  logic             step_bit;
  logic             op_we;
  logic [SELW-1:0]  op_idx;
  logic [WIDTH-1:0] op_res;

  // A load is dropped only when it hits the register a shift is walking.
  assign load_ok = !load_n && sel_in_range(32'(wr_sel), NUM_REGS)
                   && !(state_q == ST_SHIFT && wr_sel == tgt_q);

  // Ops start only from IDLE; a same-cycle load to the same register wins.
  assign op_ok = !op_n && state_q == ST_IDLE
                 && sel_in_range(32'(op_sel), NUM_REGS)
                 && !(!load_n && wr_sel == op_sel);

  // Read muxes built by matching indices so out-of-range selects read 0.
  always_comb begin
    op_val  = '0;
    tgt_val = '0;
    rd_val  = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (op_sel == SELW'(i)) op_val  = regs_q[i];
      if (tgt_q  == SELW'(i)) tgt_val = regs_q[i];
      if (rd_sel == SELW'(i)) rd_val  = regs_q[i];
    end
  end

  sap_shift_step #(.WIDTH(WIDTH)) u_shift_step (
    .data_i    (tgt_val),
    .left_i    (shop_q == OP_SHL),
    .data_o    (step_val),
    .out_bit_o (step_bit)
  );

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can leave
    // it unassigned and infer a latch.
    state_d = state_q;
    shop_d  = shop_q;
    tgt_d   = tgt_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    zero_d  = zero_q;
    op_we   = 1'b0;
    op_idx  = tgt_q;
    op_res  = '0;

    // NOTE: combinational logic uses blocking '=' so later statements see the
    // values computed above; only the always_ff uses '<='.
    unique case (state_q)
      ST_IDLE: begin
        if (op_ok) begin
          tgt_d  = op_sel;
          op_idx = op_sel;
          unique case (sap_op_e'(op))
            OP_INC: begin
              op_we   = 1'b1;
              op_res  = op_val + WIDTH'(1);
              carry_d = &op_val;
              zero_d  = (op_res == '0);
              state_d = ST_DONE;
            end
            OP_DEC: begin
              op_we   = 1'b1;
              op_res  = op_val - WIDTH'(1);
              carry_d = ~|op_val;
              zero_d  = (op_res == '0);
              state_d = ST_DONE;
            end
            OP_SHL, OP_SHR: begin
              shop_d  = sap_op_e'(op);
              carry_d = 1'b0;
              if (shamt == '0) begin
                zero_d  = (op_val == '0);
                state_d = ST_DONE;
              end else begin
                cnt_d   = shamt;
                state_d = ST_SHIFT;
              end
            end
            default: ;
          endcase
        end
      end
      ST_SHIFT: begin
        op_we   = 1'b1;
        op_res  = step_val;
        carry_d = step_bit;
        cnt_d   = cnt_q - SHW'(1);
        if (cnt_q == SHW'(1)) begin
          zero_d  = (step_val == '0);
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Load is applied last so it takes priority over any op result.
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
      if (op_we && op_idx == SELW'(i))   regs_d[i] = op_res;
      if (load_ok && wr_sel == SELW'(i)) regs_d[i] = data_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the register file is architecturally visible state that must
      // read 0 after reset, so every entry is cleared here.
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      state_q <= ST_IDLE;
      shop_q  <= OP_SHL;
      tgt_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
      state_q <= state_d;
      shop_q  <= shop_d;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
    end
  end

  assign data_out = enable_n ? '0 : rd_val;
  assign busy     = (state_q == ST_SHIFT);
  assign done     = (state_q == ST_DONE);
  assign zero     = zero_q;
  assign carry    = carry_q;

endmodule

// File: tb/tb_sap_register_bank.sv
// -----------------------------------------------------------------------------
// tb_sap_register_bank
// Directed bench for sap_register_bank (WIDTH=8, NUM_REGS=4). A behavioural
// model tracks register contents and op progress arithmetically; a compare
// process checks all outputs against it every cycle, and literal checks pin
// the hand-computed results of each scenario.
// -----------------------------------------------------------------------------
module tb_sap_register_bank;
  import sap_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       load_n;
  logic [1:0] wr_sel;
  logic [7:0] data_in;
  logic       op_n;
  logic [1:0] op;
  logic [1:0] op_sel;
  logic [3:0] shamt;
  logic       enable_n;
  logic [1:0] rd_sel;
  logic [7:0] data_out;
  logic       busy, done, zero, carry;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;
  int cyc_n    = 0;

`ifdef SAP_REGBANK_ROTATE_EN
  localparam logic [7:0] EXP_SHL3 = 8'h0C;
  localparam logic [7:0] EXP_SHL8 = 8'h81;
  localparam logic       EXP_Z8   = 1'b0;
`else
  localparam logic [7:0] EXP_SHL3 = 8'h08;
  localparam logic [7:0] EXP_SHL8 = 8'h00;
  localparam logic       EXP_Z8   = 1'b1;
`endif

  sap_register_bank dut (
    .clk      (clk),
    .reset    (reset),
    .load_n   (load_n),
    .wr_sel   (wr_sel),
    .data_in  (data_in),
    .op_n     (op_n),
    .op       (op),
    .op_sel   (op_sel),
    .shamt    (shamt),
    .enable_n (enable_n),
    .rd_sel   (rd_sel),
    .data_out (data_out),
    .busy     (busy),
    .done     (done),
    .zero     (zero),
    .carry    (carry)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] m_regs [4];
  int         m_left;      // shifts still pending
  int         m_shamt;
  logic [7:0] m_start;     // value of the target when the shift began
  logic [1:0] m_tgt;
  bit         m_left_dir;
  bit         m_done, m_zero, m_carry;

  // Value after shifting v by k positions in one go.
  function automatic logic [7:0] shift_by(input logic [7:0] v, input int k,
                                          input bit left);
    logic [15:0] w, s;
    w = {8'h00, v};
`ifdef SAP_REGBANK_ROTATE_EN
    s = left ? ((w << k) | (w >> (8 - k))) : ((w >> k) | (w << (8 - k)));
`else
    s = left ? (w << k) : (w >> k);
`endif
    return s[7:0];
  endfunction

  // Last bit to leave the word after k single shifts of v.
  function automatic logic out_bit(input logic [7:0] v, input int k,
                                   input bit left);
    return left ? v[8 - k] : v[k - 1];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
    m_left = 0; m_shamt = 0; m_start = 8'h00; m_tgt = 2'd0; m_left_dir = 1'b0;
    m_done = 1'b0; m_zero = 1'b0; m_carry = 1'b0;
  endtask

  // Advance the model by one clock edge using the inputs applied this cycle.
  task automatic model_step();
    int         left_before, k;
    bit         idle_before;
    logic [7:0] v;
    left_before = m_left;
    idle_before = (m_left == 0) && !m_done;
    m_done = 1'b0;
    if (m_left > 0) begin
      m_left--;
      k = m_shamt - m_left;
      m_regs[m_tgt] = shift_by(m_start, k, m_left_dir);
      m_carry = out_bit(m_start, k, m_left_dir);
      if (m_left == 0) begin
        m_done = 1'b1;
        m_zero = (m_regs[m_tgt] == 8'h00);
      end
    end
    if (idle_before && !op_n && !(!load_n && wr_sel == op_sel)) begin
      v = m_regs[op_sel];
      case (op)
        2'b00: begin
          m_carry = (v == 8'hFF); m_regs[op_sel] = v + 8'd1;
          m_done = 1'b1; m_zero = (m_regs[op_sel] == 8'h00);
        end
        2'b01: begin
          m_carry = (v == 8'h00); m_regs[op_sel] = v - 8'd1;
          m_done = 1'b1; m_zero = (m_regs[op_sel] == 8'h00);
        end
        default: begin
          m_carry = 1'b0;
          if (shamt == 4'd0) begin
            m_done = 1'b1; m_zero = (v == 8'h00);
          end else begin
            m_left = int'(shamt); m_shamt = int'(shamt); m_start = v;
            m_tgt = op_sel; m_left_dir = (op == 2'b10);
          end
        end
      endcase
    end
    if (!load_n && !(left_before > 0 && wr_sel == m_tgt)) m_regs[wr_sel] = data_in;
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      check("data_out", 32'(data_out), 32'(enable_n ? 8'h00 : m_regs[rd_sel]));
      check("busy",  32'(busy),  32'(m_left > 0));
      check("done",  32'(done),  32'(m_done));
      check("zero",  32'(zero),  32'(m_zero));
      check("carry", 32'(carry), 32'(m_carry));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    #1;
    cyc_n++;
    rd_sel   = 2'(cyc_n % 4);
    enable_n = (cyc_n % 5 == 4);
  endtask

  task automatic do_load(input logic [1:0] s, input logic [7:0] v);
    load_n = 1'b0; wr_sel = s; data_in = v;
    cyc();
    load_n = 1'b1;
  endtask

  task automatic do_op(input sap_op_e o, input logic [1:0] s, input logic [3:0] sh);
    op_n = 1'b0; op = o; op_sel = s; shamt = sh;
    cyc();
    op_n = 1'b1;
  endtask

  task automatic peek(input string name, input logic [1:0] s, input logic [7:0] exp);
    rd_sel = s; enable_n = 1'b0;
    #1;
    check(name, 32'(data_out), 32'(exp));
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    reset = 1'b1; load_n = 1'b1; op_n = 1'b1; enable_n = 1'b0;
    wr_sel = '0; data_in = '0; op = '0; op_sel = '0; shamt = '0; rd_sel = '0;
    model_reset();
    #12;
    for (int i = 0; i < 4; i++) peek("reset_reg", 2'(i), 8'h00);
    check("reset_busy", 32'(busy), 0);
    check("reset_done", 32'(done), 0);
    check("reset_zero", 32'(zero), 0);
    check("reset_carry", 32'(carry), 0);
    reset = 1'b0;
    @(negedge clk); #1;
    chk_en = 1'b1;

    // Reset asserted between edges in the middle of a shift.
    do_load(2'd0, 8'h33);
    do_load(2'd2, 8'hA5);
    do_op(OP_SHL, 2'd2, 4'd5);
    cyc(); cyc();
    check("midshift_busy", 32'(busy), 1);
    chk_en = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("async_busy", 32'(busy), 0);
    check("async_done", 32'(done), 0);
    peek("async_r0", 2'd0, 8'h00);
    peek("async_r2", 2'd2, 8'h00);
    @(negedge clk); #2;
    reset = 1'b0;
    model_reset();
    @(negedge clk); #1;
    chk_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      check("no_done_after_reset", 32'(done), 0);
      cyc();
    end

    // INC from all-ones wraps to zero.
    do_load(2'd1, 8'hFF);
    do_op(OP_INC, 2'd1, 4'd0);
    check("inc_done", 32'(done), 1);
    check("inc_carry", 32'(carry), 1);
    check("inc_zero", 32'(zero), 1);
    rd_sel = 2'd1; enable_n = 1'b1; #1;
    check("oe_gated", 32'(data_out), 0);
    peek("inc_r1", 2'd1, 8'h00);
    cyc();
    check("inc_done_pulse", 32'(done), 0);

    // SHL by 3 takes three busy cycles.
    do_load(2'd2, 8'h81);
    do_op(OP_SHL, 2'd2, 4'd3);
    for (int i = 0; i < 3; i++) begin
      check("shl_busy", 32'(busy), 1);
      cyc();
    end
    check("shl_busy_end", 32'(busy), 0);
    check("shl_done", 32'(done), 1);
    check("shl_carry", 32'(carry), 0);
    peek("shl_r2", 2'd2, EXP_SHL3);

    // Shift by zero completes immediately with the register unchanged.
    do_load(2'd0, 8'h01);
    do_op(OP_SHR, 2'd0, 4'd0);
    check("shr0_done", 32'(done), 1);
    check("shr0_busy", 32'(busy), 0);
    check("shr0_carry", 32'(carry), 0);
    peek("shr0_r0", 2'd0, 8'h01);
    cyc();

    // Traffic during a shift: load to target dropped, other load kept,
    // new op ignored.
    do_load(2'd3, 8'hF0);
    do_op(OP_SHR, 2'd3, 4'd4);
    load_n = 1'b0; wr_sel = 2'd3; data_in = 8'hAA;
    cyc();
    load_n = 1'b0; wr_sel = 2'd0; data_in = 8'h55;
    op_n = 1'b0; op = OP_INC; op_sel = 2'd1; shamt = 4'd0;
    cyc();
    load_n = 1'b1; op_n = 1'b1;
    cyc();
    cyc();
    check("shr4_done", 32'(done), 1);
    check("shr4_carry", 32'(carry), 0);
    peek("shr4_r3", 2'd3, 8'h0F);
    peek("busy_load_r0", 2'd0, 8'h55);
    peek("ignored_inc_r1", 2'd1, 8'h00);
    cyc();
    check("ignored_op_no_done", 32'(done), 0);

    // Same-cycle load and DEC on one register: load wins, no done.
    load_n = 1'b0; wr_sel = 2'd1; data_in = 8'h10;
    op_n = 1'b0; op = OP_DEC; op_sel = 2'd1;
    cyc();
    load_n = 1'b1; op_n = 1'b1;
    check("collide_no_done", 32'(done), 0);
    peek("collide_r1", 2'd1, 8'h10);
    cyc();
    check("collide_no_done2", 32'(done), 0);

    // Same-cycle load and INC on different registers: both proceed.
    load_n = 1'b0; wr_sel = 2'd0; data_in = 8'h22;
    op_n = 1'b0; op = OP_INC; op_sel = 2'd3;
    cyc();
    load_n = 1'b1; op_n = 1'b1;
    check("split_done", 32'(done), 1);
    peek("split_r0", 2'd0, 8'h22);
    peek("split_r3", 2'd3, 8'h10);

    // DEC from zero wraps to all-ones.
    do_load(2'd0, 8'h00);
    do_op(OP_DEC, 2'd0, 4'd0);
    check("dec_carry", 32'(carry), 1);
    check("dec_zero", 32'(zero), 0);
    peek("dec_r0", 2'd0, 8'hFF);

    // Maximum shift count.
    do_load(2'd2, 8'h81);
    do_op(OP_SHL, 2'd2, 4'd8);
    for (int i = 0; i < 8; i++) cyc();
    check("shl8_done", 32'(done), 1);
    check("shl8_carry", 32'(carry), 1);
    check("shl8_zero", 32'(zero), 32'(EXP_Z8));
    peek("shl8_r2", 2'd2, EXP_SHL8);
    cyc();
    cyc();

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sap_register_bank.md
Name: sap_register_bank

Overview:
- Parametrised successor to the single accumulator-style register: a bank of NUM_REGS general-purpose registers, each WIDTH bits wide.
- Supports bus load, gated bus output, single-cycle INC/DEC, and multi-cycle shift-by-N with a busy/done handshake.
- Sits on the SAP data bus; serves the ALU and controller as the A/B/temp register set.

Parameters:
- WIDTH, 8, data width of every register.
- NUM_REGS, 4, number of registers, minimum 2.
- SELW (localparam), $clog2(NUM_REGS), register-select width.
- SHW (localparam), $clog2(WIDTH+1), shift-amount width.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- load_n  in  1  active-low; write data_in into register wr_sel.
- wr_sel  in  SELW  load target.
- data_in  in  WIDTH  bus value to load.
- op_n  in  1  active-low; start operation op on register op_sel.
- op  in  2  00 INC, 01 DEC, 10 SHL, 11 SHR.
- op_sel  in  SELW  operation target.
- shamt  in  SHW  shift count 0..WIDTH; ignored for INC/DEC.
- enable_n  in  1  active-low output enable.
- rd_sel  in  SELW  register driven to data_out.
- data_out  out  WIDTH  reg[rd_sel] when enable_n=0, else all zeros (no tri-state).
- busy  out  1  high while a shift is in progress.
- done  out  1  one-cycle pulse when an op completes.
- zero  out  1  target register == 0 after the last completed op.
- carry  out  1  INC/DEC wrap, or last bit shifted out.

Behaviour:
- Reset (async, any time, including mid-shift): all registers 0; FSM to IDLE; busy=0, done=0, zero=0, carry=0; shift counter 0.
- data_out is combinational from the registers; a load is visible the cycle after its edge.
- FSM states: IDLE, SHIFT, DONE.
- IDLE, op_n=0, INC/DEC: target updated at that edge (mod 2^WIDTH).
  - carry=1 on INC from all-ones or DEC from 0.
  - Then go to DONE.
- IDLE, op_n=0, SHL/SHR with shamt>0:
  - Latch op, op_sel and count=shamt; go to SHIFT; carry cleared.
  - busy is high from the next cycle.
- IDLE, op_n=0, shift with shamt=0: register unchanged, carry=0, go to DONE.
- SHIFT: each cycle shift 1 bit with zero fill; carry = bit shifted out; count decrements. When count reaches 1, the final shift occurs and the FSM goes to DONE. Total busy cycles = shamt.
- DONE: done=1 for one cycle; zero updated from the target register; busy=0; return to IDLE.
- A new op_n=0 is accepted only in IDLE; in SHIFT or DONE it is ignored.
- Loads are accepted in any state, except a load to the register latched by an in-progress shift, which is dropped.
- Load and op start in the same cycle:
  - Different registers: both proceed.
  - Same register: the load wins and the op is discarded (no done).
- Simultaneous loads to the same register never occur (one write port).
- Out-of-range select (NUM_REGS not a power of 2): loads are ignored, ops are ignored (no done), reads return 0.

Optional Feature:
- Macro SAP_REGBANK_ROTATE_EN.
- Defined: SHL/SHR rotate; the bit shifted out re-enters at the opposite end; carry still reports that bit.
- Undefined: zero-fill shifts as above.

Decomposition:
- Shared package sap_pkg:
  - op encoding typedef (OP_INC, OP_DEC, OP_SHL, OP_SHR).
  - FSM state typedef (ST_IDLE, ST_SHIFT, ST_DONE).
  - Default WIDTH/NUM_REGS constants.
- One natural sub-module: sap_shift_step, a combinational one-bit shift/rotate of WIDTH bits returning result and the shifted-out bit.
- Storage and FSM stay in the top module.

Test Plan:
- Assert reset mid-shift (SHL, shamt=5, after 2 cycles) -> all registers 0 and busy=0 immediately, without waiting for clk; done never pulses.
- Load 8'hFF into r1; INC r1 -> r1=8'h00, carry=1, zero=1, done pulses one cycle after start; data_out=0 while enable_n=1.
- Load 8'h81 into r2; SHL shamt=3 -> busy high 3 cycles, r2=8'h08, carry=0 (last bit out was 0).
  - Same test with SAP_REGBANK_ROTATE_EN -> r2=8'h0C.
- SHR r0 (8'h01) shamt=0 -> r0 unchanged, carry=0, done one cycle later, busy never high.
- During SHR on r3: load r3 -> dropped; load r0=8'h55 -> accepted; op_n=0 -> ignored.
- Same-cycle load r1=8'h10 and DEC r1 -> r1=8'h10, no done pulse.
